sp_ram_param: RTL and testbench
===============================

Name: sp_ram_param

Overview:
Parametrised single-port synchronous RAM, the successor to the fixed 8-bit x 256 bidirectional-data RAM.
- Split write and read data buses, per-byte write enables, configurable read latency.
- Hardware clear engine zeroes the whole array after reset or on request.
- Sits behind bus bridges and datapath buffers as the team's generic local storage macro.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
BYTE_W, 8, byte-lane width for write enables.
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
CLEAR_ON_RST, 1, 1 = sweep array to zero after reset; 0 = contents undefined after reset.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
ce  in  1  chip enable; access request this cycle
we  in  1  1 = write, 0 = read (qualified by ce)
be  in  DATA_W/BYTE_W  byte-lane write enables, bit i covers wdata[i*BYTE_W +: BYTE_W]
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
clr_req  in  1  single-cycle pulse requesting a full-array clear
ready  out  1  1 = array accepts accesses; 0 = clear sweep in progress
rdata  out  DATA_W  read data
rvalid  out  1  1-cycle pulse, rdata valid this cycle

Behaviour:
- Reset values: ready=0, rvalid=0, rdata=0, sweep counter=0, read pipeline flushed. Array contents are not reset by rst directly.
- FSM states are CLEAR and IDLE.
- Reset state is CLEAR if CLEAR_ON_RST=1, otherwise IDLE. With CLEAR_ON_RST=0, ready goes 1 on the first rising edge after rst deasserts.
- CLEAR:
  - Each rising edge writes all-zero to mem[cnt], then cnt increments.
  - On the edge that writes address DEPTH-1: go to IDLE, ready=1, cnt wraps to 0.
  - Sweep is exactly DEPTH edges.
  - ce, we and clr_req are ignored while in CLEAR. Dropped accesses are not queued and produce no rvalid.
- IDLE:
  - clr_req=1 -> CLEAR next edge; ready=0 from that edge onward.
  - clr_req has priority over a same-cycle ce access. That access is dropped, with no write and no rvalid.
- Write (IDLE, ce=1, we=1): each byte lane i with be[i]=1 takes its wdata lane at the edge; other lanes are unchanged.
  - be=0 is a legal no-op.
  - Writes never assert rvalid.
- Read (IDLE, ce=1, we=0): be is ignored.
  - RD_LAT=1: rdata=mem[addr] and rvalid=1 after the first edge.
  - RD_LAT=2: the same appears one edge later, via an output register.
  - Reads are fully pipelined: back-to-back reads give back-to-back rvalid.
- rdata holds its last value when rvalid=0; it is never driven to X or Z.
- Single port, so there is no simultaneous read/write. A read issued on the cycle after a write to the same address returns the new data.
- Reset mid-sweep: everything returns to reset values, and the sweep restarts at address 0 once rst deasserts (if CLEAR_ON_RST=1).
- Reset with reads in flight: pending rvalid pulses are discarded.
- clr_req with reads in flight: reads accepted before the clear still complete with their pre-clear data and rvalid. The pipeline drains independently of the FSM.
- Addresses wrap naturally; there is no out-of-range case because DEPTH=2**ADDR_W.

Decomposition:
- Shared package sp_ram_pkg holds:
  - FSM state enum {CLEAR, IDLE};
  - helper function nb(DATA_W, BYTE_W) returning the byte-lane count;
  - localparam constants for the legal RD_LAT set.
- One sub-module: sp_ram_rd_pipe, a parametrised RD_LAT-stage delay line for rdata/rvalid with asynchronous reset of rvalid and rdata.
- Array, FSM and byte-lane write logic stay in the top module.
- An elaboration-time check fails the build if DATA_W % BYTE_W != 0 or RD_LAT is not in {1,2}.

Test Plan:
Bench configuration: DATA_W=32, BYTE_W=8, ADDR_W=4 (DEPTH=16).
1. Post-reset clear: rst pulse then release, CLEAR_ON_RST=1 -> ready=0 for exactly 16 edges, then 1. Reads of addr 0..15 return 0x00000000.
2. Byte-lane write: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101 -> read of addr 5 returns 0xAA22CC44; rvalid one edge after the read (RD_LAT=1), two edges after (RD_LAT=2).
3. Back-to-back reads: after writing addr n = n*0x01010101, issue reads of addr 3,4,15 on consecutive cycles -> three consecutive rvalid pulses with 0x03030303, 0x04040404, 0x0F0F0F0F.
4. Clear request with collision: write addr 7 = 0xDEADBEEF; pulse clr_req in the same cycle as a write of 0x12345678 to addr 7 -> ready low for 16 edges, and after the clear addr 7 reads 0x00000000. A ce access during the sweep gives no rvalid.
5. Reset mid-sweep: assert rst on sweep edge 9 for 2 cycles -> rvalid=0 and rdata=0 during reset. The sweep restarts and ready rises 16 edges after release.
6. Read drain across clear: write addr 2 = 0xCAFEF00D; with RD_LAT=2, issue a read of addr 2 then clr_req on the next cycle -> rvalid pulses with 0xCAFEF00D while ready=0.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types, constants and helpers for the parametrised single-port RAM.
package sp_ram_pkg;

  // Two-state controller: CLEAR sweeps zeros through the array, IDLE serves accesses.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  // Legal read latencies: registered array read, optionally followed by an output register.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Number of byte lanes in one word.
  function automatic int nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // True when the read latency is one the read pipe supports.
  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sp_ram_rd_pipe.sv
// Read-data delay line: RD_LAT register stages carrying rvalid and rdata.
// Data stages only load when their valid input is set, so rdata holds its
// last delivered word whenever rvalid is low.
module sp_ram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] rd_word,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  // Shift valid bits every cycle; move data forward only behind a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= rd_fire;
      if (rd_fire) begin
        dat[0] <= rd_word;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign rvalid = vld[RD_LAT-1];
  assign rdata  = dat[RD_LAT-1];

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// configurable read latency and a hardware clear engine that zeroes the
// array after reset or on request.
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BYTE_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          we,
  input  logic [nb(DATA_W, BYTE_W)-1:0] be,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          clr_req,
  output logic                          ready,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid
);

  localparam int NB    = nb(DATA_W, BYTE_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam ram_state_t RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : IDLE;

  // Reject configurations the byte-lane logic or the read pipe cannot build.
  generate
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_lanes
      $error("sp_ram_param: DATA_W must be a multiple of BYTE_W");
    end
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
      $error("sp_ram_param: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  ram_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              access;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] rd_word;

  // Accesses are only taken in IDLE, and a same-cycle clear request wins over them.
  always_comb begin
    access  = (state == IDLE) && ce && !clr_req;
    wr_fire = access && we;
    rd_fire = access && !we;
    wr_mask = '0;
    for (int i = 0; i < NB; i++) begin
      wr_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    end
  end

  // Array update: zero one word per cycle while sweeping, else merge enabled byte lanes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      mem[addr] <= (mem[addr] & ~wr_mask) | (wdata & wr_mask);
    end
  end

  // Controller: sweep counter, state and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RST_STATE;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd_word = mem[addr];

  sp_ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_fire (rd_fire),
    .rd_word (rd_word),
    .rvalid  (rvalid),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_sp_ram_param.sv
// Self-checking bench for sp_ram_param: two instances (RD_LAT=1 and RD_LAT=2)
// share one stimulus stream and are compared against a word-level array model.
module tb_sp_ram_param;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int NB     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce = 1'b0;
  logic              we = 1'b0;
  logic              clr_req = 1'b0;
  logic [NB-1:0]     be = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;

  logic              ready1, rvalid1, ready2, rvalid2;
  logic [DATA_W-1:0] rdata1, rdata2;

  sp_ram_param #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .RD_LAT(1), .CLEAR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .clr_req(clr_req), .ready(ready1), .rdata(rdata1), .rvalid(rvalid1)
  );

  sp_ram_param #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .RD_LAT(2), .CLEAR_ON_RST(1)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .clr_req(clr_req), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          fix;
    logic [31:0] fixv;
  } rd_t;

  typedef struct {
    logic        ce;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        clr;
    bit          fix;
    logic [31:0] exp;
  } vec_t;

  rd_t         q1[$];
  rd_t         q2[$];
  logic [31:0] mem_m [DEPTH];
  int          clear_left;
  logic        ready_exp;
  logic [31:0] last1, last2;
  int          cyc = 0;
  bit          pend_fix;
  logic [31:0] pend_fixv;
  int          vectors = 0;
  int          miscompares = 0;
  vec_t        tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void modelReset();
    q1.delete();
    q2.delete();
    last1      = '0;
    last2      = '0;
    ready_exp  = 1'b0;
    clear_left = DEPTH;
    foreach (mem_m[i]) mem_m[i] = '0;
  endfunction

  // One rising edge of the reference: a clear blanks the whole array at once,
  // since no access can observe it until the sweep of DEPTH edges is over.
  function automatic void modelEdge();
    logic [31:0] mask;
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) ready_exp = 1'b1;
    end else if (clr_req) begin
      clear_left = DEPTH;
      ready_exp  = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (ce && we) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      mem_m[addr] = (mem_m[addr] & ~mask) | (wdata & mask);
    end else if (ce) begin
      q1.push_back('{cyc, mem_m[addr], pend_fix, pend_fixv});
      q2.push_back('{cyc + 1, mem_m[addr], pend_fix, pend_fixv});
    end
  endfunction

  task automatic checkRead(input string tag, input logic rv, input logic [31:0] rd,
                           input bit due, input rd_t e, inout logic [31:0] last);
    if (due) begin
      checkOutput({tag, " rvalid"}, {31'b0, rv}, 32'd1);
      checkOutput({tag, " rdata"}, rd, e.data);
      if (e.fix) checkOutput({tag, " rdata const"}, rd, e.fixv);
      last = e.data;
    end else begin
      checkOutput({tag, " rvalid idle"}, {31'b0, rv}, 32'd0);
      checkOutput({tag, " rdata hold"}, rd, last);
    end
  endtask

  task automatic step();
    bit  d1, d2;
    rd_t e1, e2;
    @(posedge clk);
    cyc++;
    if (!rst) modelEdge();
    @(negedge clk);
    checkOutput("ready lat1", {31'b0, ready1}, {31'b0, ready_exp});
    checkOutput("ready lat2", {31'b0, ready2}, {31'b0, ready_exp});
    d1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (d1) e1 = q1.pop_front();
    checkRead("lat1", rvalid1, rdata1, d1, e1, last1);
    d2 = (q2.size() > 0) && (q2[0].due == cyc);
    if (d2) e2 = q2.pop_front();
    checkRead("lat2", rvalid2, rdata2, d2, e2, last2);
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [3:0] b, input logic [3:0] a,
                               input logic [31:0] d, input logic clr, input bit fix, input logic [31:0] fv);
    ce        = c;
    we        = w;
    be        = b;
    addr      = a;
    wdata     = d;
    clr_req   = clr;
    pend_fix  = fix;
    pend_fixv = fv;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic assertReset(input int ncyc);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset rvalid lat1", {31'b0, rvalid1}, 32'd0);
    checkOutput("reset rdata lat1", rdata1, 32'h0);
    checkOutput("reset rvalid lat2", {31'b0, rvalid2}, 32'd0);
    checkOutput("reset rdata lat2", rdata2, 32'h0);
    checkOutput("reset ready", {31'b0, ready1}, 32'd0);
    repeat (ncyc) step();
    rst = 1'b0;
  endtask

  // Count edges until ready rises, issuing reads that must be dropped meanwhile.
  task automatic waitReady(input string name, input int want);
    int n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 4'hF, 4'($urandom_range(15)), 32'h0, 1'b0, 1'b0, 32'h0);
      n++;
    end while (ready1 !== 1'b1 && n < 40);
    checkOutput(name, 32'(n), 32'(want));
  endtask

  initial begin
    // Post-reset reads, byte-lane merge, then a ramp of words read back-to-back.
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back('{1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'hF, 4'd5, 32'h0, 1'b0, 1'b1, 32'hAA22CC44});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 1'b1, 32'hAA22CC44});
    for (int n = 0; n < DEPTH; n++)
      tbl.push_back('{1'b1, 1'b1, 4'hF, 4'(n), 32'h01010101 * 32'(n), 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b1, 32'h03030303});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd4, 32'h0, 1'b0, 1'b1, 32'h04040404});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd15, 32'h0, 1'b0, 1'b1, 32'h0F0F0F0F});

    assertReset(3);
    waitReady("post-reset sweep edges", 16);

    foreach (tbl[i])
      applyStimulus(tbl[i].ce, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
                    tbl[i].clr, tbl[i].fix, tbl[i].exp);
    idle(3);

    // Clear request colliding with a write: the write is lost.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1, 1'b0, 32'h0);
    checkOutput("clr ready drop", {31'b0, ready1}, 32'd0);
    waitReady("clr sweep edges", 16);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0, 1'b1, 32'h0);
    idle(3);

    // Read in flight across a clear request still delivers pre-clear data.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("drain rvalid", {31'b0, rvalid2}, 32'd1);
    checkOutput("drain rdata", rdata2, 32'hCAFEF00D);
    checkOutput("drain ready", {31'b0, ready2}, 32'd0);
    waitReady("drain sweep edges", 16);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b1, 32'h0);
    idle(3);

    // Reset with a read in flight, then reset in the middle of a sweep.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd3, 32'h33333333, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b1, 32'h33333333);
    assertReset(2);
    idle(8);
    assertReset(2);
    waitReady("restarted sweep edges", 16);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b1, 32'h0);
    idle(3);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)),
                    4'($urandom_range(15)), $urandom, 1'($urandom_range(49) == 0), 1'b0, 32'h0);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
